// File: rtl/lcd_write_engine.sv
// Parallel-bus writer for an HD44780-style character LCD: one byte per handshake, timed E strobe.
// Define LCD_INIT_SEQ_EN to run the power-on wait and the built-in init command sequence after reset.
module lcd_write_engine #(
  parameter int SETUP_CYC      = 3,
  parameter int E_PULSE_CYC    = 25,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERON_CYC    = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  output logic [7:0] D,
  output logic       RS,
  output logic       RW,
  output logic       E,
  output logic       busy,
  output logic       init_done
);

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       d_q, d_nxt;
  logic             rs_q, rs_nxt;
  logic             done_q, done_nxt;
  logic             e_q;
  logic             last;

`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] INIT_LEN = 3'd7;
  logic [2:0] idx, idx_nxt;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2, 3'd3: return 8'h38;
      3'd4:                   return 8'h0C;
      3'd5:                   return 8'h01;
      default:                return 8'h06;
    endcase
  endfunction
`endif

  function automatic logic [CNT_W-1:0] cyc(input int n);
    return CNT_W'(n);
  endfunction

  // Clear (0x01) and home (0x02/0x03) commands need the long settle time.
  function automatic logic [CNT_W-1:0] wait_for(input logic [7:0] d, input logic rs);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03))
      return cyc(CLEAR_WAIT_CYC);
    return cyc(CMD_WAIT_CYC);
  endfunction

  // A state entered with count N lasts N cycles; a count of 0 or 1 both mean one cycle.
  assign last = (cnt <= CNT_W'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    d_nxt     = d_q;
    rs_nxt    = rs_q;
    done_nxt  = done_q;
`ifdef LCD_INIT_SEQ_EN
    idx_nxt   = idx;
`endif
    case (state)
      PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
        if (last) state_nxt = INIT;
`else
        state_nxt = IDLE;
        done_nxt  = 1'b1;
`endif
      end
      INIT: begin
`ifdef LCD_INIT_SEQ_EN
        d_nxt     = init_cmd(idx);
        rs_nxt    = 1'b0;
        idx_nxt   = idx + 3'd1;
        state_nxt = SETUP;
        cnt_nxt   = cyc(SETUP_CYC);
`else
        state_nxt = IDLE;
`endif
      end
      IDLE: begin
        if (in_valid && in_ready) begin
          d_nxt     = in_data;
          rs_nxt    = in_rs;
          state_nxt = SETUP;
          cnt_nxt   = cyc(SETUP_CYC);
        end
      end
      SETUP: begin
        if (last) begin
          state_nxt = PULSE;
          cnt_nxt   = cyc(E_PULSE_CYC);
        end
      end
      PULSE: begin
        if (last) begin
          state_nxt = HOLD;
          cnt_nxt   = cyc(HOLD_CYC);
        end
      end
      HOLD: begin
        if (last) begin
          state_nxt = WAIT;
          cnt_nxt   = wait_for(d_q, rs_q);
        end
      end
      WAIT: begin
        if (last) begin
`ifdef LCD_INIT_SEQ_EN
          if (done_q) begin
            state_nxt = IDLE;
          end else if (idx == INIT_LEN) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = INIT;
          end
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = PWRUP;
    endcase
  end

  // E is registered from the next state so the strobe is glitch-free and falls with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= PWRUP;
      cnt    <= cyc(POWERON_CYC);
      d_q    <= 8'h00;
      rs_q   <= 1'b0;
      done_q <= 1'b0;
      e_q    <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      idx    <= 3'd0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_q    <= d_nxt;
      rs_q   <= rs_nxt;
      done_q <= done_nxt;
      e_q    <= (state_nxt == PULSE);
`ifdef LCD_INIT_SEQ_EN
      idx    <= idx_nxt;
`endif
    end
  end

  assign in_ready  = (state == IDLE) && done_q;
  assign D         = d_q;
  assign RS        = rs_q;
  assign RW        = 1'b0;
  assign E         = e_q;
  assign busy      = (state != IDLE);
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Randomized self-checking bench for lcd_write_engine; expectations come from per-cycle history
// of the LCD pins compared against the timing rules (setup/pulse/hold/wait) computed arithmetically.
module tb_lcd_write_engine;
  localparam int S = 2, P = 4, H = 1, CW = 10, CLW = 30, PO = 50;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [7:0] D;
  logic       RS, RW, E, busy, init_done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] d_h   [HMAX];
  logic       rs_h  [HMAX];
  logic       e_h   [HMAX];
  logic       rdy_h [HMAX];

  lcd_write_engine #(
    .SETUP_CYC(S), .E_PULSE_CYC(P), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CW), .CLEAR_WAIT_CYC(CLW), .POWERON_CYC(PO)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rs(in_rs), .D(D), .RS(RS), .RW(RW), .E(E),
    .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HMAX) begin
      d_h[cyc]   <= D;
      rs_h[cyc]  <= RS;
      e_h[cyc]   <= E;
      rdy_h[cyc] <= in_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference: which bytes need the long post-write wait.
  function automatic int exp_wait(input logic [7:0] d, input logic rs);
    if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return CLW;
    return CW;
  endfunction

  function automatic int find_rise(input int from);
    for (int i = (from < 1) ? 1 : from; i <= cyc && i < HMAX; i++)
      if (e_h[i] === 1'b1 && e_h[i-1] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_fall(input int from);
    for (int i = from + 1; i <= cyc && i < HMAX; i++)
      if (e_h[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_ready(input int from);
    for (int i = from; i <= cyc && i < HMAX; i++)
      if (rdy_h[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic rs, output int t);
    in_valid = 1'b1;
    in_data  = d;
    in_rs    = rs;
    @(posedge clk);
    #1;
    t = cyc;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (E !== 1'b0) begin failures++; $display("FAIL reset_E got=%b want=0", E); end
    checks++; if (D !== 8'h00) begin failures++; $display("FAIL reset_D got=%h want=00", D); end
    checks++; if ({RS, RW} !== 2'b00) begin failures++; $display("FAIL reset_RS_RW got=%b want=00", {RS, RW}); end
    checks++; if ({in_ready, busy, init_done} !== 3'b010) begin
      failures++; $display("FAIL reset_ctrl got rdy/busy/done=%b want=010", {in_ready, busy, init_done});
    end
    repeat (3) @(negedge clk);
    checks++; if ({E, in_ready, busy, init_done} !== 4'b0010) begin
      failures++; $display("FAIL reset_held got E/rdy/busy/done=%b want=0010", {E, in_ready, busy, init_done});
    end
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init();
    logic [7:0] cmds [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int rel, r, f, rp, bad, n;
    bit ok;
    #2 rst = 1'b1;
    rel = cyc;
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL init_timeout got in_ready=%b want=1", in_ready); return; end
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL init_done got=%b want=1", init_done); end
    r = rel; rp = -1; bad = 0; n = 0; f = -1;
    for (int k = 0; k < 7; k++) begin
      r = find_rise(r + 1);
      if (r < 0) break;
      n++;
      f = find_fall(r);
      if (d_h[r] !== cmds[k] || rs_h[r] !== 1'b0 || f - r != P) bad++;
      if (rp >= 0 && r - rp != P + H + exp_wait(cmds[k-1], 1'b0) + 1 + S) bad++;
      rp = r;
    end
    checks++; if (n != 7) begin failures++; $display("FAIL init_count got=%0d want=7", n); end
    checks++; if (find_rise(rp + 1) != -1) begin failures++; $display("FAIL init_extra got extra pulse want none"); end
    checks++; if (bad != 0) begin failures++; $display("FAIL init_seq got %0d bad pulses want 0", bad); end
    checks++; if (f < 0 || find_ready(rel) != f + H + CW) begin
      failures++; $display("FAIL init_ready got=%0d want=%0d", find_ready(rel), f + H + CW);
    end
  endtask
`else
  task automatic test_no_init();
    int bad;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({in_ready, init_done, busy} !== 3'b110) begin
      failures++; $display("FAIL noinit_first_edge got rdy/done/busy=%b want=110", {in_ready, init_done, busy});
    end
    bad = 0;
    repeat (20) begin @(negedge clk); if (E !== 1'b0) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL noinit_E got %0d E-high cycles want 0", bad); end
  endtask
`endif

  task automatic test_data_write();
    logic [7:0] d;
    logic rs;
    int t, r, f, ir, bad;
    bit ok;
    for (int n = 0; n < 12; n++) begin
      d  = (n == 0) ? 8'h41 : 8'($urandom);
      rs = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wait_idle(400, ok);
      checks++; if (!ok) begin failures++; $display("FAIL write_idle got in_ready=%b want=1", in_ready); return; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(d, rs, t);
      repeat (3) @(negedge clk);
      in_valid = 1'b1; in_data = ~d;
      @(negedge clk);
      in_valid = 1'b0;
      wait_idle(400, ok);
      r  = find_rise(t);
      f  = (r < 0) ? -1 : find_fall(r);
      ir = find_ready(t);
      checks++; if (r != t + S) begin failures++; $display("FAIL write_setup d=%h got rise=%0d want=%0d", d, r, t + S); continue; end
      checks++; if (f - r != P) begin failures++; $display("FAIL write_width d=%h got=%0d want=%0d", d, f - r, P); continue; end
      bad = 0;
      for (int i = r - S; i < f + H; i++) if (d_h[i] !== d || rs_h[i] !== rs) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL write_stable d=%h rs=%b got %0d unstable cycles want 0", d, rs, bad); end
      checks++; if (ir - f - H != exp_wait(d, rs)) begin
        failures++; $display("FAIL write_wait d=%h rs=%b got=%0d want=%0d", d, rs, ir - f - H, exp_wait(d, rs));
      end
      repeat (4) @(negedge clk);
      #1;
      checks++; if (find_rise(f + 1) != -1 || in_ready !== 1'b1 || D !== d || RW !== 1'b0) begin
        failures++; $display("FAIL write_after d=%h got D=%h rdy=%b RW=%b want D=%h rdy=1 RW=0 no pulse", d, D, in_ready, RW, d);
      end
    end
  endtask

  task automatic test_clear();
    logic [7:0] dv [7] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h81};
    logic       rv [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int t, r, f, ir;
    bit ok;
    for (int n = 0; n < 7; n++) begin
      wait_idle(400, ok);
      send(dv[n], rv[n], t);
      wait_idle(400, ok);
      r  = find_rise(t);
      f  = (r < 0) ? -1 : find_fall(r);
      ir = find_ready(t);
      checks++; if (!ok || r < 0 || d_h[r] !== dv[n] || ir - f - H != exp_wait(dv[n], rv[n])) begin
        failures++; $display("FAIL clear_wait d=%h rs=%b got wait=%0d want=%0d", dv[n], rv[n], ir - f - H, exp_wait(dv[n], rv[n]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, r1, r2;
    bit ok;
    wait_idle(400, ok);
    in_valid = 1'b1; in_data = 8'h48; in_rs = 1'b1;
    @(posedge clk);
    #1;
    t1 = cyc;
    in_data = 8'h49;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    t2 = cyc;
    in_valid = 1'b0;
    wait_idle(400, ok);
    r1 = find_rise(t1);
    r2 = (r1 < 0) ? -1 : find_rise(r1 + 1);
    checks++; if (t2 - t1 != S + P + H + CW + 1) begin
      failures++; $display("FAIL b2b_accept got=%0d want=%0d", t2 - t1, S + P + H + CW + 1);
    end
    checks++; if (r1 < 0 || r2 < 0 || d_h[r1] !== 8'h48 || d_h[r2] !== 8'h49) begin
      failures++; $display("FAIL b2b_bytes got rises=%0d,%0d want bytes 48,49", r1, r2);
    end else begin
      checks++; if (r2 - r1 != 18) begin failures++; $display("FAIL b2b_spacing got=%0d want=18", r2 - r1); end
      checks++; if (find_rise(r2 + 1) != -1) begin failures++; $display("FAIL b2b_dup got extra pulse want none"); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int t, rel, n, r;
    bit ok;
    wait_idle(400, ok);
    send(8'h5A, 1'b1, t);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (E === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_pulse got E=%b want=1", E); end
    #2 rst = 1'b0;
    #1;
    checks++; if (E !== 1'b0 || D !== 8'h00 || busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_async got E=%b D=%h busy=%b rdy=%b want E=0 D=00 busy=1 rdy=0", E, D, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    rel = cyc;
`ifdef LCD_INIT_SEQ_EN
    #1;
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b want=0", init_done); end
    wait_idle(3000, ok);
    n = 0; r = rel;
    for (int k = 0; k < 10; k++) begin
      r = find_rise(r + 1);
      if (r < 0) break;
      n++;
    end
    checks++; if (!ok || n != 7 || init_done !== 1'b1) begin
      failures++; $display("FAIL rstmid_reinit got pulses=%0d done=%b want 7 and 1", n, init_done);
    end
`else
    n = 0; r = 0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1 || find_rise(rel) != -1) begin
      failures++; $display("FAIL rstmid_restart got rdy=%b want=1 with no pulse", in_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`else
    test_no_init();
`endif
    test_data_write();
    test_clear();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
